// File: rtl/midi_msg_parser.sv
`timescale 1ns/1ps
// midi_msg_parser: MIDI byte-stream parser with running status, emitting note on/off events.
// Define MIDI_PARSER_CC_EN to also emit control-change events (evt_type = 2).
module midi_msg_parser #(
    parameter bit         OMNI    = 1'b1,
    parameter logic [3:0] CHANNEL = 4'd0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       rx_re,
    output logic       evt_valid,
    output logic [1:0] evt_type,
    output logic [3:0] evt_channel,
    output logic [6:0] evt_data1,
    output logic [6:0] evt_data2
);

    typedef enum logic [1:0] {StIdle, StWaitD1, StWaitD2, StWaitD1Only} state_e;

    state_e     state_q, state_d;
    logic [7:0] status_q, status_d;
    logic [6:0] d1_q, d1_d;
    logic       ack_pend_q, ack_pend_d;

    logic       evt_valid_d;
    logic [1:0] evt_type_d;
    logic [3:0] evt_channel_d;
    logic [6:0] evt_data1_d, evt_data2_d;

    logic       chan_ok;

    // Gated by resetn so the strobe reads as 0 while the block is held in reset.
    assign rx_re   = rx_valid & ~ack_pend_q & resetn;
    assign chan_ok = OMNI || (status_q[3:0] == CHANNEL);

    // Hold off further reads until the UART's valid flag has been seen low.
    always_comb begin
        ack_pend_d = ack_pend_q;
        if (rx_re) begin
            ack_pend_d = 1'b1;
        end else if (!rx_valid) begin
            ack_pend_d = 1'b0;
        end
    end

    always_comb begin
        state_d       = state_q;
        status_d      = status_q;
        d1_d          = d1_q;
        evt_valid_d   = 1'b0;
        evt_type_d    = evt_type;
        evt_channel_d = evt_channel;
        evt_data1_d   = evt_data1;
        evt_data2_d   = evt_data2;

        if (rx_re) begin
            if (rx_data >= 8'hF8) begin
                // Real-time bytes are transparent to the parser.
            end else if (rx_data >= 8'hF0) begin
                status_d = 8'h00;
                state_d  = StIdle;
            end else if (rx_data[7]) begin
                status_d = rx_data;
                if (rx_data[7:4] == 4'hC || rx_data[7:4] == 4'hD) begin
                    state_d = StWaitD1Only;
                end else begin
                    state_d = StWaitD1;
                end
            end else begin
                unique case (state_q)
                    StIdle: ;
                    StWaitD1: begin
                        d1_d    = rx_data[6:0];
                        state_d = StWaitD2;
                    end
                    StWaitD2: begin
                        state_d = StWaitD1;
                        if (chan_ok) begin
                            unique case (status_q[7:4])
                                4'h9: begin
                                    evt_valid_d = 1'b1;
                                    evt_type_d  = (rx_data[6:0] != 7'd0) ? 2'd1 : 2'd0;
                                end
                                4'h8: begin
                                    evt_valid_d = 1'b1;
                                    evt_type_d  = 2'd0;
                                end
`ifdef MIDI_PARSER_CC_EN
                                4'hB: begin
                                    evt_valid_d = 1'b1;
                                    evt_type_d  = 2'd2;
                                end
`endif
                                default: ;
                            endcase
                        end
                        if (evt_valid_d) begin
                            evt_channel_d = status_q[3:0];
                            evt_data1_d   = d1_q;
                            evt_data2_d   = rx_data[6:0];
                        end
                    end
                    StWaitD1Only: ;
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            status_q    <= 8'h00;
            d1_q        <= 7'd0;
            ack_pend_q  <= 1'b0;
            evt_valid   <= 1'b0;
            evt_type    <= 2'd0;
            evt_channel <= 4'd0;
            evt_data1   <= 7'd0;
            evt_data2   <= 7'd0;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            d1_q        <= d1_d;
            ack_pend_q  <= ack_pend_d;
            evt_valid   <= evt_valid_d;
            evt_type    <= evt_type_d;
            evt_channel <= evt_channel_d;
            evt_data1   <= evt_data1_d;
            evt_data2   <= evt_data2_d;
        end
    end

endmodule

// File: tb/tb_midi_msg_parser.sv
`timescale 1ns/1ps
// Bench for midi_msg_parser: directed test-plan streams plus random traffic, checked by a
// scoreboard fed from a message-level MIDI model (omni instance and channel-2-only instance).
module tb_midi_msg_parser;

    typedef struct packed {
        logic [1:0]  t;
        logic [3:0]  ch;
        logic [6:0]  d1;
        logic [6:0]  d2;
        logic [31:0] cyc;
    } evt_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_re0, rx_re1;
    logic       ev0, ev1;
    logic [1:0] ty0, ty1;
    logic [3:0] ch0, ch1;
    logic [6:0] a0, a1, b0, b1;

    logic [31:0] cyc = 32'd0;
    int unsigned re_cnt = 0;
    int unsigned sent = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    evt_t       q0[$];
    evt_t       q1[$];
    logic [7:0] m_status;
    logic [6:0] m_data[$];
    logic [20:0] last0, last1;

    midi_msg_parser u_omni (
        .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data), .rx_re(rx_re0),
        .evt_valid(ev0), .evt_type(ty0), .evt_channel(ch0), .evt_data1(a0), .evt_data2(b0)
    );

    midi_msg_parser #(.OMNI(1'b0), .CHANNEL(4'd2)) u_ch2 (
        .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data), .rx_re(rx_re1),
        .evt_valid(ev1), .evt_type(ty1), .evt_channel(ch1), .evt_data1(a1), .evt_data2(b1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 32'd1;
        if (resetn && rx_re0) re_cnt <= re_cnt + 1;
    end

    // Message-level model: running status plus a list of collected data bytes.
    function automatic void model_byte(input logic [7:0] b, input logic [31:0] at);
        int   need;
        bit   emit;
        evt_t e;
        if (b >= 8'hF8) return;
        if (b >= 8'hF0) begin
            m_status = 8'h00;
            m_data.delete();
            return;
        end
        if (b[7]) begin
            m_status = b;
            m_data.delete();
            return;
        end
        if (m_status == 8'h00) return;
        m_data.push_back(b[6:0]);
        need = (m_status[7:4] == 4'hC || m_status[7:4] == 4'hD) ? 1 : 2;
        if (m_data.size() < need) return;
        emit = 1'b0;
        e    = '0;
        if (need == 2) begin
            e.ch  = m_status[3:0];
            e.d1  = m_data[0];
            e.d2  = m_data[1];
            e.cyc = at + 32'd1;
            case (m_status[7:4])
                4'h9: begin emit = 1'b1; e.t = (m_data[1] == 7'd0) ? 2'd0 : 2'd1; end
                4'h8: begin emit = 1'b1; e.t = 2'd0; end
`ifdef MIDI_PARSER_CC_EN
                4'hB: begin emit = 1'b1; e.t = 2'd2; end
`endif
                default: emit = 1'b0;
            endcase
        end
        m_data.delete();
        if (emit) begin
            q0.push_back(e);
            if (e.ch == 4'd2) q1.push_back(e);
        end
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        #1;
        n = 0;
        while (!rx_re0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!rx_re0) begin
            $display("FAIL handshake byte %h: rx_re stayed 0, required 1 within 50 cycles", b);
            rx_valid = 1'b0;
            return;
        end
        model_byte(b, cyc);
        sent++;
        // Keep valid high a little after the read, as a slow UART flag would.
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        resetn   = 1'b0;
        rx_valid = 1'b1;
        m_status = 8'h00;
        m_data.delete();
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    function automatic void check_dut(input int idx, input logic v, input logic [1:0] t,
                                      input logic [3:0] c, input logic [6:0] d1,
                                      input logic [6:0] d2, input logic re);
        evt_t got, want;
        got = {t, c, d1, d2, cyc};
        if (!resetn) begin
            checks++;
            if ({v, t, c, d1, d2, re} != 22'd0) begin
                errors++;
                $display("FAIL reset%0d outputs got v=%b t=%0d ch=%0d d1=%h d2=%h re=%b, required 0",
                         idx, v, t, c, d1, d2, re);
            end
            if (idx == 0) last0 = '0; else last1 = '0;
        end else if (v) begin
            checks++;
            if ((idx == 0 && q0.size() == 0) || (idx == 1 && q1.size() == 0)) begin
                errors++;
                $display("FAIL evt%0d unexpected: got t=%0d ch=%0d d1=%h d2=%h at cyc %0d, required none",
                         idx, t, c, d1, d2, cyc);
            end else begin
                want = (idx == 0) ? q0.pop_front() : q1.pop_front();
                if (got != want) begin
                    errors++;
                    $display("FAIL evt%0d got t=%0d ch=%0d d1=%h d2=%h cyc=%0d, required t=%0d ch=%0d d1=%h d2=%h cyc=%0d",
                             idx, t, c, d1, d2, cyc, want.t, want.ch, want.d1, want.d2, want.cyc);
                end
            end
            if (idx == 0) last0 = got[52:32]; else last1 = got[52:32];
        end else begin
            checks++;
            if (got[52:32] != ((idx == 0) ? last0 : last1)) begin
                errors++;
                $display("FAIL hold%0d fields changed without evt_valid: got %h, required %h",
                         idx, got[52:32], (idx == 0) ? last0 : last1);
            end
        end
    endfunction

    task automatic monitor();
        forever begin
            @(negedge clk);
            check_dut(0, ev0, ty0, ch0, a0, b0, rx_re0);
            check_dut(1, ev1, ty1, ch1, a1, b1, rx_re1);
        end
    endtask

    task automatic checkpoint(input string name);
        repeat (4) @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL %s pending: got %0d/%0d events outstanding, required 0/0",
                     name, q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
        checks++;
        if (re_cnt != sent) begin
            errors++;
            $display("FAIL %s rx_re count: got %0d, required %0d", name, re_cnt, sent);
        end
    endtask

    initial begin
        logic [7:0] b;
        int         r;
        resetn   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        m_status = 8'h00;
        last0    = '0;
        last1    = '0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        checkpoint("basic_note_on");

        send_byte(8'h91); send_byte(8'h40); send_byte(8'h7F); send_byte(8'h40); send_byte(8'h00);
        checkpoint("running_status");

        send_byte(8'h90); send_byte(8'h3C); send_byte(8'hF8); send_byte(8'h50);
        send_byte(8'hC0); send_byte(8'h05); send_byte(8'h90); send_byte(8'h30); send_byte(8'h10);
        checkpoint("realtime_interleave");

        send_byte(8'hF0); send_byte(8'h7E); send_byte(8'h01); send_byte(8'hF7); send_byte(8'h45);
        send_byte(8'h80); send_byte(8'h45); send_byte(8'h20);
        checkpoint("sysex");

        send_byte(8'h93); send_byte(8'h3C); send_byte(8'h40);
        send_byte(8'h92); send_byte(8'h3C); send_byte(8'h40);
        send_byte(8'hB2); send_byte(8'h07); send_byte(8'h64);
        send_byte(8'hA2); send_byte(8'h10); send_byte(8'h20);
        send_byte(8'hE2); send_byte(8'h00); send_byte(8'h40);
        checkpoint("channel_filter");

        send_byte(8'h90);
        do_reset();
        send_byte(8'h3C); send_byte(8'h40);
        checkpoint("reset_mid_message");

        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      b = 8'($urandom_range(0, 127));
            else if (r < 85) b = {4'($urandom_range(8, 14)), 4'($urandom_range(0, 3))};
            else if (r < 92) b = 8'($urandom_range(8'hF0, 8'hF7));
            else             b = 8'($urandom_range(8'hF8, 8'hFF));
            send_byte(b);
            if (i == 250) do_reset();
        end
        checkpoint("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/midi_msg_parser.md
Name: midi_msg_parser

Overview:
- Byte-stream MIDI parser directly downstream of the UART receiver in the midi_voice_control path.
- Consumes received bytes through the UART's valid/read-strobe interface and tracks running status.
- Emits single-cycle note-on, note-off and (optionally) control-change events to the voice controller.
- Discards real-time, system and SysEx traffic without losing sync.

Parameters:
- OMNI, 1, 1 = accept all channels; 0 = accept only CHANNEL.
- CHANNEL, 0, 4-bit MIDI channel (0-15) to accept when OMNI=0.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset; asynchronous, active-low
- rx_valid  in  1  received byte available (UART recv_buf_valid)
- rx_data  in  8  received byte (UART reg_dat_do)
- rx_re  out  1  byte-consume strobe (to UART reg_dat_re)
- evt_valid  out  1  one-cycle event strobe
- evt_type  out  2  0 = note off, 1 = note on, 2 = control change
- evt_channel  out  4  MIDI channel of event
- evt_data1  out  7  note number / controller number
- evt_data2  out  7  velocity / controller value

Behaviour:
- Clock and reset:
  - Single clock domain.
  - resetn low asynchronously clears all state: state = IDLE, status = 0, ack_pend = 0.
  - All outputs reset to 0: evt_valid, evt_type, evt_channel, evt_data1, evt_data2, rx_re.
- Read handshake:
  - rx_re = rx_valid & ~ack_pend (combinational).
  - A byte is accepted in any cycle where rx_re = 1.
  - ack_pend sets on the cycle after an accept and clears when rx_valid is sampled low. This prevents a double read while the UART's valid flag is still falling.
  - If a new byte makes rx_valid re-assert while ack_pend = 1, it is read once ack_pend clears.
- Byte classes, evaluated on the accepted byte b:
  - b >= 0xF8 (real-time): ignored; state, status and pending data are unchanged.
  - 0xF0 <= b <= 0xF7 (system common / SysEx): running status cleared; state = IDLE. Subsequent data bytes are dropped until the next channel status byte.
  - 0x80 <= b <= 0xEF (channel status): status = b.
    - Needs 1 data byte (0xC_, 0xD_): state = WAIT_D1_ONLY.
    - Otherwise: state = WAIT_D1.
  - b < 0x80 (data): handled per state below.
- State machine (IDLE, WAIT_D1, WAIT_D2, WAIT_D1_ONLY):
  - IDLE + data: byte dropped; stay in IDLE.
  - WAIT_D1 + data: d1 = b[6:0]; go to WAIT_D2.
  - WAIT_D2 + data: d2 = b[6:0]; message complete; go to WAIT_D1 (running status).
  - WAIT_D1_ONLY + data: message complete with no event; stay in WAIT_D1_ONLY (running status).
  - A status byte in any state aborts the partial message; d1 is discarded.
- Event generation on message completion:
  - Event is generated only if the channel passes the filter: OMNI=1, or status[3:0] == CHANNEL.
  - 0x9n with d2 != 0: evt_type = 1.
  - 0x9n with d2 == 0: evt_type = 0 (velocity-0 note-on is a note-off); evt_data2 = 0.
  - 0x8n: evt_type = 0; evt_data2 = received release velocity.
  - 0xBn: per Optional Feature.
  - 0xAn, 0xEn: parsed, no event.
- Event timing:
  - evt_valid rises on the clock edge following the accepting cycle of the final data byte (latency 1) and is high for exactly one cycle.
  - evt_type, evt_channel, evt_data1 and evt_data2 are registered with evt_valid and hold their values until the next event.
  - Back-to-back events are at least 2 cycles apart, a consequence of the handshake.
- Reset mid-message: all partial state is lost; the next data byte without a fresh status byte is dropped.

Optional Feature:
- Macro: MIDI_PARSER_CC_EN.
- Defined: a completed 0xBn message emits evt_type = 2, evt_data1 = controller number, evt_data2 = value, subject to the channel filter.
- Undefined: 0xBn messages are parsed for sync only and emit no event; evt_type = 2 is never produced.

Test Plan:
- Bytes 0x90,0x3C,0x64 -> one evt_valid with type 1, ch 0, d1 0x3C, d2 0x64; rx_re pulses exactly 3 times.
- Running status: 0x91,0x40,0x7F,0x40,0x00 -> two events: (type 1, ch 1, 0x40, 0x7F) then (type 0, ch 1, 0x40, 0x00).
- Real-time interleave: 0x90,0x3C,0xF8,0x50 -> single event type 1, d1 0x3C, d2 0x50. Also 0xC0,0x05,0x90,0x30,0x10 -> only one event (type 1, 0x30, 0x10).
- SysEx: 0xF0,0x7E,0x01,0xF7,0x45 -> no events; then 0x80,0x45,0x20 -> type 0, d1 0x45, d2 0x20.
- OMNI=0, CHANNEL=2: 0x93,0x3C,0x40 -> no event; 0x92,0x3C,0x40 -> event, ch 2. With MIDI_PARSER_CC_EN, 0xB2,0x07,0x64 -> type 2, 0x07, 0x64; without the macro -> no event.
- Assert resetn low between 0x90 and 0x3C, then feed 0x3C,0x40 -> no event; all outputs 0 during reset.
